// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the half-word SRAM controller.
// Latency: none (definitions only).
// Backpressure: not applicable.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BASE_ADDR_DEF     = 1024;
    localparam int ACCESS_CYCLES_DEF = 2;
    localparam int SRAM_AW_DEF       = 18;
    localparam int SRAM_DW           = 16;
    localparam int CNT_W             = 4;

    // Half-word index of the low half of the addressed word; caller truncates to SRAM width.
    function automatic logic [31:0] low_half_of(input logic [31:0] addr, input logic [31:0] base);
        return ((addr - base) >> 2) << 1;
    endfunction

endpackage

// File: rtl/sram_model.sv
// Behavioural 2^AW x 16 asynchronous SRAM with a merged data bus, for simulation only.
// Latency: reads are combinational; writes land on the clock edge while we_n is low.
// Backpressure: none; always accepts.
module sram_model #(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   dq_out,
    input  logic          dq_oe,
    input  logic          we_n,
    input  logic          oe_n,
    output logic [15:0]   dq_in
);

    logic [15:0] mem [0:(1<<AW)-1];
    logic [15:0] bus;

    // Undriven bus reads back as pulled-up ones.
    assign bus   = dq_oe ? dq_out : (!oe_n ? mem[addr] : 16'hFFFF);
    assign dq_in = bus;

    always_ff @(posedge clk) begin
        if (!we_n) begin
            mem[addr] <= bus;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Turns one 32-bit load/store into two half-word accesses on an async 16-bit SRAM.
// Latency: ready returns in cycle 2*ACCESS_CYCLES+1 after the request is first seen.
// Backpressure: ready low freezes the pipeline until the DONE cycle; idle pipeline never stalls.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int BASE_ADDR     = BASE_ADDR_DEF,
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
    parameter int SRAM_AW       = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [SRAM_AW-1:0] lo_addr_q;
    logic [SRAM_AW-1:0] lo_addr_nxt;
    logic [SRAM_AW-1:0] hi_addr;
    logic [31:0]        wdata_q;
    logic               op_wr_q;
    logic               req;
    logic               last;

    assign req         = rd_en | wr_en;
    assign last        = (cnt == CNT_W'(ACCESS_CYCLES - 1));
    assign lo_addr_nxt = SRAM_AW'(low_half_of(address, 32'(BASE_ADDR)));
    assign hi_addr     = {lo_addr_q[SRAM_AW-1:1], 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus outputs decode straight from state so an async reset idles the bus immediately.
    always_comb begin
        state_nxt   = state;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        case (state)
            IDLE: begin
                ready = !req;
                if (req) begin
                    state_nxt = LOW;
                end
            end
            LOW: begin
                sram_addr   = lo_addr_q;
                sram_dq_out = op_wr_q ? wdata_q[15:0] : '0;
                sram_dq_oe  = op_wr_q;
                sram_we_n   = !op_wr_q;
                sram_oe_n   = op_wr_q;
                if (last) begin
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                sram_addr   = hi_addr;
                sram_dq_out = op_wr_q ? wdata_q[31:16] : '0;
                sram_dq_oe  = op_wr_q;
                sram_we_n   = !op_wr_q;
                sram_oe_n   = op_wr_q;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            lo_addr_q <= '0;
            wdata_q   <= '0;
            op_wr_q   <= 1'b0;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cnt       <= '0;
                        lo_addr_q <= lo_addr_nxt;
                        wdata_q   <= write_data;
                        op_wr_q   <= wr_en;
                    end
                end
                LOW: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last && !op_wr_q) begin
                        read_data[15:0] <= sram_dq_in;
                    end
                end
                HIGH: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last && !op_wr_q) begin
                        read_data[31:16] <= sram_dq_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: vector table of word accesses plus reset, latching and timing sequences.
module tb_sram_controller;
    import sram_controller_pkg::*;

    localparam int AC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] dq_out, dq_in;
    logic        dq_oe, we_n, oe_n;

    logic        a1_req, a4_req;
    logic [31:0] a1_rd, a4_rd;
    logic        a1_ready, a4_ready;
    logic [17:0] a1_addr, a4_addr;
    logic [15:0] a1_dq, a4_dq;
    logic        a1_oe, a4_oe, a1_we_n, a4_we_n, a1_oe_n, a4_oe_n;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    sram_controller #(.ACCESS_CYCLES(AC)) u_dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(dq_out), .sram_dq_oe(dq_oe),
        .sram_dq_in(dq_in), .sram_we_n(we_n), .sram_oe_n(oe_n)
    );

    sram_model #(.AW(18)) u_mem (
        .clk(clk), .addr(sram_addr), .dq_out(dq_out), .dq_oe(dq_oe),
        .we_n(we_n), .oe_n(oe_n), .dq_in(dq_in)
    );

    sram_controller #(.ACCESS_CYCLES(1)) u_ac1 (
        .clk(clk), .rst(rst), .rd_en(1'b0), .wr_en(a1_req), .address(32'd1024),
        .write_data(32'h0), .read_data(a1_rd), .ready(a1_ready),
        .sram_addr(a1_addr), .sram_dq_out(a1_dq), .sram_dq_oe(a1_oe),
        .sram_dq_in(16'h0), .sram_we_n(a1_we_n), .sram_oe_n(a1_oe_n)
    );

    sram_controller #(.ACCESS_CYCLES(4)) u_ac4 (
        .clk(clk), .rst(rst), .rd_en(1'b0), .wr_en(a4_req), .address(32'd1024),
        .write_data(32'h0), .read_data(a4_rd), .ready(a4_ready),
        .sram_addr(a4_addr), .sram_dq_out(a4_dq), .sram_dq_oe(a4_oe),
        .sram_dq_in(16'h0), .sram_we_n(a4_we_n), .sram_oe_n(a4_oe_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One pipeline access: request held until the ready cycle, dropped on the following edge.
    task automatic run_access(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] exp_rd,
                              input logic [17:0] lo, input bit chg, input string tag);
        int          cyc;
        bit          got;
        logic [31:0] exp;
        sb_q.push_back(exp_rd);
        @(posedge clk); #1;
        wr_en = w; rd_en = r; address = a; write_data = d;
        cyc = 0;
        got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk({tag, " low addr"}, 32'(sram_addr), 32'(lo));
                chk({tag, " we_n"}, 32'(we_n), 32'(!w));
                chk({tag, " oe_n"}, 32'(oe_n), 32'(w));
            end
            if (cyc == AC + 1) chk({tag, " high addr"}, 32'(sram_addr), 32'(lo + 18'd1));
            if (ready) begin
                got = 1;
            end else begin
                if (chg && cyc == 1) begin
                    address    = 32'd2000;
                    write_data = 32'h0BAD0BAD;
                end
                cyc++;
            end
        end
        chk({tag, " ready cycle"}, 32'(cyc), 32'(2 * AC + 1));
        exp = sb_q.pop_front();
        if (got) chk({tag, " read_data"}, read_data, exp);
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0;
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic [17:0] lo;
    } vec_t;

    vec_t        vecs[6];
    logic [15:0] snap;
    int          c1, c4;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0,        18'd0};
        vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h0,        32'hDEADBEEF, 18'd0};
        vecs[2] = '{1'b1, 1'b0, 32'd1039, 32'hCAFEF00D, 32'hDEADBEEF, 18'd6};
        vecs[3] = '{1'b0, 1'b1, 32'd1039, 32'h0,        32'hCAFEF00D, 18'd6};
        vecs[4] = '{1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 32'hCAFEF00D, 18'h3FFFE};
        vecs[5] = '{1'b0, 1'b1, 32'd1020, 32'h0,        32'hA5A55A5A, 18'h3FFFE};

        rst = 1; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
        a1_req = 0; a4_req = 0;
        #3;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset we_n", 32'(we_n), 32'd1);
        chk("reset oe_n", 32'(oe_n), 32'd1);
        chk("reset dq_oe", 32'(dq_oe), 32'd0);
        chk("reset sram_addr", 32'(sram_addr), 32'd0);
        chk("reset dq_out", 32'(dq_out), 32'd0);
        chk("reset read_data", read_data, 32'd0);
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 6; i++) begin
            run_access(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].exp_rd,
                       vecs[i].lo, 1'b0, $sformatf("vec%0d", i));
            if (vecs[i].w) begin
                chk($sformatf("vec%0d mem lo", i), 32'(u_mem.mem[vecs[i].lo]), 32'(vecs[i].d[15:0]));
                chk($sformatf("vec%0d mem hi", i), 32'(u_mem.mem[vecs[i].lo + 18'd1]), 32'(vecs[i].d[31:16]));
            end
        end

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle cyc%0d", i), 32'({ready, we_n, oe_n, dq_oe}), 32'b1110);
        end

        // Reset lands in the first HIGH cycle of a write, before the high half is committed.
        @(posedge clk); #1;
        wr_en = 1; address = 32'd1024; write_data = 32'h11112222;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre-reset we_n", 32'(we_n), 32'd0);
        chk("pre-reset addr", 32'(sram_addr), 32'd1);
        rst = 1;
        #1;
        chk("async rst we_n", 32'(we_n), 32'd1);
        chk("async rst dq_oe", 32'(dq_oe), 32'd0);
        chk("async rst oe_n", 32'(oe_n), 32'd1);
        chk("async rst addr", 32'(sram_addr), 32'd0);
        chk("async rst read_data", read_data, 32'd0);
        wr_en = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("post-reset idle ready", 32'(ready), 32'd1);
        chk("post-reset mem1", 32'(u_mem.mem[1]), 32'h0000DEAD);
        chk("post-reset mem0", 32'(u_mem.mem[0]), 32'h00002222);

        snap = u_mem.mem[488];
        run_access(1'b1, 1'b1, 32'd1028, 32'h12345678, 32'h0, 18'd2, 1'b1, "both");
        chk("both mem2", 32'(u_mem.mem[2]), 32'h00005678);
        chk("both mem3", 32'(u_mem.mem[3]), 32'h00001234);
        chk("both mem488 untouched", 32'(u_mem.mem[488]), 32'(snap));
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, 32'h12345678, 18'd2, 1'b0, "readback");

        c1 = -1;
        c4 = -1;
        @(posedge clk); #1;
        a1_req = 1; a4_req = 1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (a1_ready && c1 < 0) c1 = cyc;
            if (a4_ready && c4 < 0) c4 = cyc;
            @(posedge clk); #1;
            if (c1 >= 0) a1_req = 0;
            if (c4 >= 0) a4_req = 0;
        end
        chk("ac1 ready cycle", 32'(c1), 32'd3);
        chk("ac4 ready cycle", 32'(c4), 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits between the MEM stage and an external 16-bit asynchronous SRAM.
- Replaces the single-cycle data memory with a multi-cycle access of two half-words per 32-bit word.
- Drives a ready signal that the top level ORs into the pipeline freeze, so that all pipeline registers hold while an access is in flight.
- Accepts one load or store per request and returns 32-bit read data registered.

Parameters:
- BASE_ADDR, 1024: byte address of data-memory word 0; subtracted from the ALU result.
- ACCESS_CYCLES, 2: clock cycles spent on each half-word SRAM access (1..15).
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-high
- rd_en  in  1  load request, from the EXE/MEM register MEM_R_EN
- wr_en  in  1  store request, from the EXE/MEM register MEM_W_EN
- address  in  32  byte address, from the EXE/MEM register ALU result
- write_data  in  32  store value, from the EXE/MEM register ST_Val
- read_data  out  32  loaded word; valid in the DONE state and held until the next read completes
- ready  out  1  combinational; 0 stalls the whole pipeline
- sram_addr  out  SRAM_AW  half-word address
- sram_dq_out  out  16  write data driven onto the SRAM bus
- sram_dq_oe  out  1  1 = controller drives the bus
- sram_dq_in  in  16  data read from the SRAM bus
- sram_we_n  out  1  SRAM write enable, active-low
- sram_oe_n  out  1  SRAM output enable, active-low

Behaviour:
- Reset (asynchronous, any state, including mid-access):
  - state = IDLE; counter = 0; read_data = 0.
  - sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_out = 0.
  - An interrupted access is abandoned, not resumed.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2. Bits [1:0] are ignored.
  - low half-word address = {word[SRAM_AW-2:0], 1'b0}; high half-word address = low + 1.
  - The result wraps modulo 2^SRAM_AW; there is no range error.
- Request encoding: req = rd_en | wr_en. If both are set, the access is a write.
- States: IDLE, LOW, HIGH, DONE.
  - IDLE:
    - If req, latch address, write_data and op (write/read), clear the counter, and go to LOW.
    - Otherwise stay in IDLE.
    - Bus idle: we_n = 1, oe_n = 1, dq_oe = 0.
  - LOW:
    - sram_addr = low half-word address.
    - Write: we_n = 0, dq_oe = 1, dq_out = wdata[15:0].
    - Read: oe_n = 0, and sram_dq_in is sampled into read_data[15:0] at the end of the last cycle.
    - The counter increments each cycle. At ACCESS_CYCLES-1, clear the counter and go to HIGH.
  - HIGH: same as LOW, using the high half-word address and bits [31:16]; at the end go to DONE.
  - DONE:
    - Bus idle.
    - ready = 1 for exactly this cycle, so the pipeline advances the requesting instruction.
    - Go to IDLE unconditionally.
- ready equals !req in IDLE, 1 in DONE, and 0 in LOW and HIGH.
- Latency:
  - A request first seen in cycle 0 produces ready = 1 in cycle 2*ACCESS_CYCLES+1 (cycle 5 by default).
  - An idle pipeline with no request never stalls.
- Back-to-back requests: after DONE, a new request present in IDLE stalls again. The same instruction is not re-executed, because the pipeline has already advanced at the DONE edge.
- Latched values: address, data and op are latched in IDLE. Changes to the inputs during LOW or HIGH are ignored.
- read_data updates only on reads. Writes leave read_data unchanged.
- The interface is synchronous on the pipeline side. No combinational path exists from sram_dq_in to ready.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, LOW=2'd1, HIGH=2'd2, DONE=2'd3), BASE_ADDR, and the SRAM widths.
- Sub-module sram_model: a behavioural 2^SRAM_AW x 16 asynchronous SRAM for the bench and top-level simulation. It combines dq_out and dq_oe into a tristate bus. It is not synthesised.
- The controller itself is a single module with no further hierarchy.

Test Plan:
1. Store then load:
   - Stimulus: wr_en with address = 1024, write_data = 32'hDEADBEEF; after completion, rd_en with address = 1024.
   - Required: SRAM[0] = 16'hBEEF and SRAM[1] = 16'hDEAD; ready is 0 for cycles 0-4 and 1 in cycle 5 of each access; read_data = 32'hDEADBEEF in the read's DONE cycle.
2. Address mapping:
   - Stimulus: load at address = 1024+12+3.
   - Required: sram_addr = 6 during LOW and 7 during HIGH; the byte offset is ignored.
3. No request:
   - Stimulus: rd_en = wr_en = 0 for 20 cycles.
   - Required: ready stays 1, we_n = oe_n = 1, dq_oe = 0 throughout.
4. Reset mid-access:
   - Stimulus: assert rst asynchronously during HIGH of a write.
   - Required: we_n = 1 and dq_oe = 0 immediately, not waiting for a clock edge; state is IDLE after reset release; SRAM[1] is unchanged.
5. Simultaneous requests and latching:
   - Stimulus: rd_en = wr_en = 1 with address = 1028, write_data = 32'h12345678; change address to 2000 during LOW.
   - Required: the access is a write to half-word addresses 2 and 3 only; read_data is unchanged.
6. Parameterisation:
   - Stimulus: ACCESS_CYCLES = 1, then 4.
   - Required: ready rises in cycle 3 and cycle 9 respectively.
